// File: rtl/mem_bus_responder_if.sv
// Load/store bus between the core (master) and the memory responder (slave).
// The err signal exists only when MEM_ERR_EN is defined.
interface mem_bus_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
`ifdef MEM_ERR_EN
  logic        err;
`endif

  modport master (
    output req, we, addr, wdata, wstrb,
`ifdef MEM_ERR_EN
    input  err,
`endif
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
`ifdef MEM_ERR_EN
    output err,
`endif
    output ready, rdata
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-addressed RAM responder with WAIT_CYCLES wait states; optional MEM_ERR_EN adds err.
// States: IDLE accept request | WAIT count down wait states | RESP one-cycle ready pulse
module mem_bus_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                reset,
  mem_bus_responder_if.slave bus
);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [7:0] W_LOAD = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_a_we;
  logic [31:0]           w_a_addr;
  logic [31:0]           w_a_wdata;
  logic [3:0]            w_a_wstrb;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oor;

  assign w_accept     = (r_state == S_IDLE) && bus.req;
  assign w_enter_resp = (w_next == S_RESP) && !reset;

  // With zero wait states the access completes on the accept edge, so it uses the live bus
  always_comb begin
    if (r_state == S_IDLE) begin
      w_a_we    = bus.we;
      w_a_addr  = bus.addr;
      w_a_wdata = bus.wdata;
      w_a_wstrb = bus.wstrb;
    end else begin
      w_a_we    = r_we;
      w_a_addr  = r_addr;
      w_a_wdata = r_wdata;
      w_a_wstrb = r_wstrb;
    end
  end

  assign w_idx = w_a_addr[DEPTH_LOG2+1:2];

`ifdef MEM_ERR_EN
  assign w_oor = (|w_a_addr[31:DEPTH_LOG2+2]) || (|w_a_addr[1:0]);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{w_a_addr[31:DEPTH_LOG2+2], w_a_addr[1:0]};
  assign w_oor         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req) w_next = (W_LOAD == 8'd0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 8'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (r_state == S_RESP);
    bus.rdata = r_rdata;
`ifdef MEM_ERR_EN
    bus.err   = (r_state == S_RESP) && r_err;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_cnt   <= W_LOAD;
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_wstrb <= bus.wstrb;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_resp && w_a_we && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_a_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
      end
    end
  end

  // Read-before-write: rdata captures the word as it was before this edge's update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= w_oor ? 32'd0 : r_mem[w_idx];
      r_err   <= w_oor;
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one W=2 and one W=0 instance against a cycle-timeline model.
module tb_mem_bus_responder;
  localparam int DL = 10;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  wstrb_s [2];
  logic        rdy_s   [2];
  logic [31:0] rd_s    [2];
  logic        err_s   [2];

  mem_bus_responder_if bus0();
  mem_bus_responder_if bus1();

  assign bus0.req = req_s[0];  assign bus0.we = we_s[0];  assign bus0.addr = addr_s[0];
  assign bus0.wdata = wdata_s[0];  assign bus0.wstrb = wstrb_s[0];
  assign bus1.req = req_s[1];  assign bus1.we = we_s[1];  assign bus1.addr = addr_s[1];
  assign bus1.wdata = wdata_s[1];  assign bus1.wstrb = wstrb_s[1];
  assign rdy_s[0] = bus0.ready;  assign rd_s[0] = bus0.rdata;
  assign rdy_s[1] = bus1.ready;  assign rd_s[1] = bus1.rdata;
`ifdef MEM_ERR_EN
  assign err_s[0] = bus0.err;  assign err_s[1] = bus1.err;
`else
  assign err_s[0] = 1'b0;      assign err_s[1] = 1'b0;
`endif

  mem_bus_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .reset(rst_s[0]), .bus(bus0));
  mem_bus_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .reset(rst_s[1]), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Timeline model: an accepted request completes exactly W edges later,
  // and the responder can accept again W+2 edges after acceptance.
  int          cyc = 0;
  logic [31:0] mm [2][1 << DL];
  bit          mv [2][1 << DL];
  int          next_acc  [2] = '{0, 0};
  bit          pend      [2] = '{0, 0};
  int          pend_edge [2];
  bit          p_we      [2];
  logic [31:0] p_addr    [2];
  logic [31:0] p_wd      [2];
  logic [3:0]  p_st      [2];
  bit          e_rdy     [2] = '{0, 0};
  logic [31:0] e_rd      [2];
  bit          e_known   [2] = '{0, 0};
  bit          e_err     [2] = '{0, 0};

  function automatic int wcyc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic model_complete(input int d);
    int idx;
    bit oor;
    idx = int'(p_addr[d][DL+1:2]);
    oor = 1'b0;
`ifdef MEM_ERR_EN
    oor = (p_addr[d][31:DL+2] != '0) || (p_addr[d][1:0] != 2'b00);
`endif
    if (oor) begin
      e_rd[d] = 32'd0;  e_known[d] = 1'b1;  e_err[d] = 1'b1;
    end else begin
      e_rd[d] = mm[d][idx];  e_known[d] = mv[d][idx];
      if (p_we[d]) begin
        for (int i = 0; i < 4; i++)
          if (p_st[d][i]) mm[d][idx][8*i +: 8] = p_wd[d][8*i +: 8];
        if (p_st[d] == 4'hF) mv[d][idx] = 1'b1;
      end
    end
  endtask

  task automatic model_step(input int d);
    if (rst_s[d]) begin
      pend[d] = 1'b0;  e_rdy[d] = 1'b0;  e_err[d] = 1'b0;
      e_rd[d] = 32'd0; e_known[d] = 1'b1; next_acc[d] = cyc + 1;
    end else begin
      e_rdy[d] = 1'b0;  e_err[d] = 1'b0;
      if (!pend[d] && req_s[d] && cyc >= next_acc[d]) begin
        pend[d] = 1'b1;  pend_edge[d] = cyc + wcyc(d);  next_acc[d] = cyc + wcyc(d) + 2;
        p_we[d] = we_s[d];  p_addr[d] = addr_s[d];  p_wd[d] = wdata_s[d];  p_st[d] = wstrb_s[d];
      end
      if (pend[d] && cyc == pend_edge[d]) begin
        pend[d] = 1'b0;  e_rdy[d] = 1'b1;
        model_complete(d);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d@%0d", d, cyc), 32'(rdy_s[d]), 32'(e_rdy[d]));
        if (e_known[d]) chk($sformatf("rdata%0d@%0d", d, cyc), rd_s[d], e_rd[d]);
`ifdef MEM_ERR_EN
        chk($sformatf("err%0d@%0d", d, cyc), 32'(err_s[d]), 32'(e_err[d]));
`endif
      end
    end
  end

  task automatic xact(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit alt, input logic [31:0] alt_a,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = we; addr_s[d] = a; wdata_s[d] = wd; wstrb_s[d] = st;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rdy_s[d]) begin
        lat = n;
        break;
      end
      if (alt) begin
        addr_s[d] = alt_a; wdata_s[d] = $urandom; wstrb_s[d] = 4'($urandom); we_s[d] = 1'($urandom);
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL timeout dut%0d: got no ready want ready within 40 cycles", d);
    end
    rd = rd_s[d];
    er = err_s[d];
    req_s[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, ra, a;
    logic        er;
    int          lat, k, n1, n2;
    logic [31:0] got [2];

    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; req_s[d] = 1'b0; we_s[d] = 1'b0;
      addr_s[d] = '0; wdata_s[d] = '0; wstrb_s[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready%0d", d), 32'(rdy_s[d]), 32'd0);
      chk($sformatf("reset_rdata%0d", d), rd_s[d], 32'd0);
      rst_s[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++)
        xact(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, '0, rd, er, lat);

    // W=2 directed
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, '0, rd, er, lat);
    chk("latency_w2", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("read_full", rd, 32'hDEADBEEF);
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0, '0, rd, er, lat);
    chk("write_returns_old", rd, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("read_partial", rd, 32'hDEADBEAA);
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, '0, rd, er, lat);
    chk("noop_write_ready", 32'(lat), 32'd3);
    chk("noop_write_old", rd, 32'hDEADBEAA);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("read_after_noop", rd, 32'hDEADBEAA);
    xact(0, 1'b1, 32'h20, 32'h20202020, 4'hF, 1'b0, '0, rd, er, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h20, rd, er, lat);
    chk("mid_wait_change", rd, 32'hDEADBEAA);

    xact(0, 1'b1, 32'h30, 32'h11112222, 4'hF, 1'b0, '0, rd, er, lat);
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h30; wdata_s[0] = 32'h99999999; wstrb_s[0] = 4'hF;
    @(negedge clk);
    rst_s[0] = 1'b1; req_s[0] = 1'b0;
    @(negedge clk);
    rst_s[0] = 1'b0;
    xact(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("reset_in_wait_nowrite", rd, 32'h11112222);

    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10;
    for (int n = 0; n < 10 && !rdy_s[0]; n++) @(negedge clk);
    chk("resp_before_reset", rd_s[0], 32'hDEADBEAA);
    rst_s[0] = 1'b1; req_s[0] = 1'b0;
    @(negedge clk);
    chk("reset_in_resp_ready", 32'(rdy_s[0]), 32'd0);
    chk("reset_in_resp_rdata", rd_s[0], 32'd0);
    rst_s[0] = 1'b0;

    // W=0 directed
    xact(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b0, '0, rd, er, lat);
    chk("latency_w0", 32'(lat), 32'd1);
    xact(1, 1'b1, 32'h4, 32'hB4B4B4B4, 4'hF, 1'b0, '0, rd, er, lat);
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h0;
    k = 0; n1 = 0; n2 = 0;
    for (int n = 1; n <= 20 && k < 2; n++) begin
      @(negedge clk);
      if (rdy_s[1]) begin
        got[k] = rd_s[1];
        if (k == 0) begin n1 = n; addr_s[1] = 32'h4; end
        else n2 = n;
        k++;
      end
    end
    req_s[1] = 1'b0;
    chk("b2b_count", 32'(k), 32'd2);
    chk("b2b_first", got[0], 32'hA0A0A0A0);
    chk("b2b_second", got[1], 32'hB4B4B4B4);
    chk("b2b_spacing", 32'(n2 - n1), 32'd2);

    // Out-of-range / aliasing
    xact(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, '0, rd, er, lat);
`ifdef MEM_ERR_EN
    xact(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, '0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("oor_no_write", rd, 32'h0BADF00D);
    chk("inrange_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h2, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("misaligned_err", 32'(er), 32'd1);
`else
    xact(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, '0, rd, er, lat);
    chk("alias_old", rd, 32'h0BADF00D);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, '0, rd, er, lat);
    chk("alias_write", rd, 32'h12345678);
`endif

    for (int t = 0; t < 300; t++) begin
      int d;
      d = int'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      ra = 32'($urandom_range(0, 31)) << 2;
      xact(d, 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), ra, rd, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
